// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty/half occupancy flags and
// registered overflow/underflow pulses for rejected requests.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_enb,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_enb,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             half,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  // Storage array; no reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en_ok;
  logic          rd_en_ok;

  // Flags decode straight from the count register.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign half  = (count >= HALF_CNT);

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  assign wr_en_ok = wr_enb && (!full || rd_enb);
  assign rd_en_ok = rd_enb && !empty;

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_en_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Write pointer advances on every accepted write and wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
    end else if (wr_en_ok) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Registered read: data appears the cycle after an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (rd_en_ok) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + AW'(1);
    end
  end

  // Occupancy count; simultaneous accepted read and write leave it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      unique case ({wr_en_ok, rd_en_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // One-cycle error pulses for rejected write/read requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_enb && full && !rd_enb;
      underflow <= rd_enb && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard-based bench for sync_fifo (WIDTH=8, DEPTH=16).
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_enb;
  logic [7:0] wr_data;
  logic       rd_enb;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       half;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  // Scoreboard and reference state
  logic [7:0] sb[$];
  logic [7:0] exp_rd;
  logic       exp_ovf;
  logic       exp_udf;
  logic       last_rd_ok;

  sync_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_enb    (wr_enb),
    .wr_data   (wr_data),
    .rd_enb    (rd_enb),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .half      (half),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of requests, update the scoreboard, sample #1 after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
    logic m_full, m_empty, w_ok, r_ok;
    m_full  = (sb.size() == 16);
    m_empty = (sb.size() == 0);
    w_ok    = we && (!m_full || re);
    r_ok    = re && !m_empty;
    exp_ovf = we && m_full && !re;
    exp_udf = re && m_empty;
    if (r_ok) exp_rd = sb.pop_front();
    if (w_ok) sb.push_back(wd);
    last_rd_ok = r_ok;
    wr_enb  = we;
    wr_data = wd;
    rd_enb  = re;
    @(posedge clk);
    #1;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_rd  = 8'h00;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (half !== 1'b0) begin failures++; $display("FAIL reset_half got=%b exp=0", half); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rstn = 1'b1;
    $display("reset: empty=%b full=%b half=%b rd_data=%h", empty, full, half, rd_data);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      checks++; if (half !== (i >= 8)) begin failures++; $display("FAIL fill_half[%0d] got=%b exp=%b", i, half, (i >= 8)); end
      checks++; if (full !== (i == 16)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 16)); end
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow[%0d] got=%b exp=0", i, overflow); end
      $display("write %02h: half=%b full=%b", i[7:0], half, full);
    end
    cycle(1'b1, 8'hAA, 1'b0);
    checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_pulse got=%b exp=%b", overflow, exp_ovf); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    $display("write aa when full: overflow=%b", overflow);
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_count_full got=%b exp=1", full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, exp_rd); end
      checks++; if (empty !== (i == 16)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == 16)); end
      $display("read: rd_data=%h exp=%h empty=%b", rd_data, exp_rd, empty);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (underflow !== exp_udf) begin failures++; $display("FAIL udf_pulse got=%b exp=%b", underflow, exp_udf); end
    checks++; if (rd_data !== 8'h10) begin failures++; $display("FAIL udf_hold got=%h exp=10", rd_data); end
    $display("read when empty: underflow=%b rd_data=%h", underflow, rd_data);
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simfull_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simfull_ovf got=%b exp=0", overflow); end
    checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL simfull_data got=%h exp=%h", rd_data, exp_rd); end
    $display("rd+wr when full: rd_data=%h full=%b overflow=%b", rd_data, full, overflow);
    while (sb.size() > 0) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL simfull_drain got=%h exp=%h", rd_data, exp_rd); end
      $display("read: rd_data=%h exp=%h", rd_data, exp_rd);
    end
    cycle(1'b1, 8'h55, 1'b1);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL simempty_udf got=%b exp=1", underflow); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL simempty_empty got=%b exp=0", empty); end
    checks++; if (half !== 1'b0) begin failures++; $display("FAIL simempty_half got=%b exp=0", half); end
    $display("rd+wr when empty: underflow=%b empty=%b", underflow, empty);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (rd_data !== 8'h55) begin failures++; $display("FAIL simempty_data got=%h exp=55", rd_data); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simempty_after got=%b exp=1", empty); end
    $display("read: rd_data=%h", rd_data);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    d = 8'h80;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, d, 1'b0);
      d++;
    end
    for (int k = 0; k < 40; k++) begin
      case (k % 3)
        0: begin cycle(1'b1, d, 1'b0); d++; end
        1: cycle(1'b0, 8'h00, 1'b1);
        default: begin cycle(1'b1, d, 1'b1); d++; end
      endcase
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL wrap_err[%0d] got=%b%b exp=00", k, overflow, underflow); end
      if (last_rd_ok) begin
        checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", k, rd_data, exp_rd); end
        $display("wrap read: rd_data=%h exp=%h", rd_data, exp_rd);
      end
    end
    while (sb.size() > 0) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", rd_data, exp_rd); end
      $display("wrap drain: rd_data=%h exp=%h", rd_data, exp_rd);
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midrst_rd_data got=%h exp=00", rd_data); end
    $display("mid reset: empty=%b rd_data=%h", empty, rd_data);
    #1;
    rstn = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (rd_data !== 8'h77) begin failures++; $display("FAIL midrst_data got=%h exp=77", rd_data); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_after got=%b exp=1", empty); end
    $display("post reset read: rd_data=%h", rd_data);
  endtask

  initial begin
    rstn       = 1'b1;
    wr_enb     = 1'b0;
    wr_data    = 8'h00;
    rd_enb     = 1'b0;
    last_rd_ok = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
